// File: rtl/ctrl_sequencer.sv
// rtl/ctrl_sequencer.sv - one-state-per-clock microsequencer for the three-bus CPU datapath
// Define CTRL_SEQ_MEMWAIT_EN to hold F1, ld T6 and st T7 until mem_ready.
module ctrl_sequencer #(
  parameter int MUL_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stop,
  input  logic [31:0] IRdata,
  input  logic        con_ff,
  input  logic        mem_ready,
  output logic        run,
  output logic        clear,
  output logic [26:0] ctrl,
  output logic [4:0]  alu_opcode
);

  localparam int PC_OUT = 0, MAR_IN = 1, INC_PC = 2, Z_IN = 3, ZLOW_OUT = 4, ZHIGH_OUT = 5;
  localparam int PC_IN = 6, READ = 7, WRITE = 8, MDR_IN = 9, MDR_OUT = 10, IR_IN = 11;
  localparam int GRA = 12, GRB = 13, GRC = 14, R_IN = 15, R_OUT = 16, BA_OUT = 17, C_OUT = 18;
  localparam int Y_IN = 19, HI_IN = 20, LO_IN = 21, HI_OUT = 22, LO_OUT = 23, CONN_IN = 24;
  localparam int INPORT_OUT = 25, OUTPORT_IN = 26;

  localparam logic [4:0] OP_LD = 5'd0, OP_LDI = 5'd1, OP_ST = 5'd2, OP_ADD = 5'd3, OP_SUB = 5'd4;
  localparam logic [4:0] OP_AND = 5'd5, OP_OR = 5'd6, OP_SHR = 5'd7, OP_SHL = 5'd9, OP_ROR = 5'd10;
  localparam logic [4:0] OP_ROL = 5'd11, OP_ADDI = 5'd12, OP_ANDI = 5'd13, OP_ORI = 5'd14;
  localparam logic [4:0] OP_MUL = 5'd15, OP_DIV = 5'd16, OP_NEG = 5'd17, OP_NOT = 5'd18;
  localparam logic [4:0] OP_BR = 5'd19, OP_JR = 5'd20, OP_JAL = 5'd21, OP_IN = 5'd22;
  localparam logic [4:0] OP_OUT = 5'd23, OP_MFHI = 5'd24, OP_MFLO = 5'd25, OP_HALT = 5'd27;

  localparam logic [4:0] ALU_ADD = 5'd1;
  localparam logic [3:0] CNT_LAST = 4'(MUL_CYCLES - 1);

  typedef enum logic [3:0] {
    S_RESET, S_F0, S_F1, S_F2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t      state, next_state, last_step;
  logic [3:0]  mul_cnt;
  logic [4:0]  op;
  logic        is_muldiv, mul_hold, mem_hold, mem_wait;
  logic        unused_ir;

  assign op        = IRdata[31:27];
  assign unused_ir = ^IRdata[26:0];
  assign is_muldiv = (op == OP_MUL) || (op == OP_DIV);

`ifdef CTRL_SEQ_MEMWAIT_EN
  assign mem_wait = !mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_wait = 1'b0;
`endif

  function automatic logic [4:0] alu_for(input logic [4:0] o);
    case (o)
      OP_ADD, OP_ADDI: alu_for = 5'd1;
      OP_SUB:          alu_for = 5'd2;
      OP_MUL:          alu_for = 5'd3;
      OP_DIV:          alu_for = 5'd4;
      OP_SHR:          alu_for = 5'd5;
      OP_SHL:          alu_for = 5'd6;
      OP_ROR:          alu_for = 5'd8;
      OP_ROL:          alu_for = 5'd9;
      OP_AND, OP_ANDI: alu_for = 5'd10;
      OP_OR, OP_ORI:   alu_for = 5'd11;
      OP_NEG:          alu_for = 5'd12;
      OP_NOT:          alu_for = 5'd15;
      default:         alu_for = 5'd0;
    endcase
  endfunction

  always_comb begin
    last_step = S_T3;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
      OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: last_step = S_T5;
      OP_NEG, OP_NOT, OP_JAL:           last_step = S_T4;
      OP_MUL, OP_DIV, OP_BR:            last_step = S_T6;
      OP_LD, OP_ST:                     last_step = S_T7;
      default:                          last_step = S_T3;
    endcase
  end

  assign mul_hold = (state == S_T4) && is_muldiv && (mul_cnt != CNT_LAST);
  assign mem_hold = mem_wait && ((state == S_F1) ||
                                 (state == S_T6 && op == OP_LD) ||
                                 (state == S_T7 && op == OP_ST));

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_RESET;
      mul_cnt <= 4'd0;
    end else begin
      state   <= next_state;
      mul_cnt <= mul_hold ? mul_cnt + 4'd1 : 4'd0;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_RESET: next_state = S_F0;
      S_F0:    next_state = S_F1;
      S_F1:    next_state = mem_hold ? S_F1 : S_F2;
      S_F2:    next_state = S_T3;
      S_HALT:  next_state = S_HALT;
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        if (mul_hold || mem_hold)
          next_state = state;
        else if (state == S_T3 && op == OP_HALT)
          next_state = S_HALT;
        // T7 always completes so a changed IR can never strand the sequencer
        else if (state == last_step || state == S_T7)
          next_state = stop ? S_HALT : S_F0;
        else if (state == S_T3)
          next_state = S_T4;
        else if (state == S_T4)
          next_state = S_T5;
        else if (state == S_T5)
          next_state = S_T6;
        else
          next_state = S_T7;
      end
      default: next_state = S_RESET;
    endcase
    if (reset)
      next_state = S_RESET;
  end

  always_comb begin
    ctrl       = '0;
    alu_opcode = 5'd0;
    run        = (state != S_HALT) && (state != S_RESET);
    clear      = (state == S_RESET);
    case (state)
      S_F0: begin
        ctrl[PC_OUT] = 1'b1; ctrl[MAR_IN] = 1'b1; ctrl[INC_PC] = 1'b1; ctrl[Z_IN] = 1'b1;
      end
      S_F1: begin
        ctrl[ZLOW_OUT] = 1'b1; ctrl[PC_IN] = 1'b1; ctrl[READ] = 1'b1; ctrl[MDR_IN] = 1'b1;
      end
      S_F2: begin
        ctrl[MDR_OUT] = 1'b1; ctrl[IR_IN] = 1'b1;
      end
      S_T3: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
          OP_ADDI, OP_ANDI, OP_ORI: begin
            ctrl[GRB] = 1'b1; ctrl[R_OUT] = 1'b1; ctrl[Y_IN] = 1'b1;
          end
          OP_NEG, OP_NOT: begin
            ctrl[GRB] = 1'b1; ctrl[R_OUT] = 1'b1; ctrl[Z_IN] = 1'b1; alu_opcode = alu_for(op);
          end
          OP_MUL, OP_DIV: begin
            ctrl[GRA] = 1'b1; ctrl[R_OUT] = 1'b1; ctrl[Y_IN] = 1'b1;
          end
          OP_LD, OP_LDI, OP_ST: begin
            ctrl[GRB] = 1'b1; ctrl[BA_OUT] = 1'b1; ctrl[Y_IN] = 1'b1;
          end
          OP_BR:   begin ctrl[GRA] = 1'b1; ctrl[R_OUT] = 1'b1; ctrl[CONN_IN] = 1'b1; end
          OP_JR:   begin ctrl[GRA] = 1'b1; ctrl[R_OUT] = 1'b1; ctrl[PC_IN] = 1'b1; end
          OP_JAL:  begin ctrl[PC_OUT] = 1'b1; ctrl[GRB] = 1'b1; ctrl[R_IN] = 1'b1; end
          OP_MFHI: begin ctrl[HI_OUT] = 1'b1; ctrl[GRA] = 1'b1; ctrl[R_IN] = 1'b1; end
          OP_MFLO: begin ctrl[LO_OUT] = 1'b1; ctrl[GRA] = 1'b1; ctrl[R_IN] = 1'b1; end
          OP_IN:   begin ctrl[INPORT_OUT] = 1'b1; ctrl[GRA] = 1'b1; ctrl[R_IN] = 1'b1; end
          OP_OUT:  begin ctrl[GRA] = 1'b1; ctrl[R_OUT] = 1'b1; ctrl[OUTPORT_IN] = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL: begin
            ctrl[GRC] = 1'b1; ctrl[R_OUT] = 1'b1; ctrl[Z_IN] = 1'b1; alu_opcode = alu_for(op);
          end
          OP_NEG, OP_NOT: begin
            ctrl[ZLOW_OUT] = 1'b1; ctrl[GRA] = 1'b1; ctrl[R_IN] = 1'b1;
          end
          OP_ADDI, OP_ANDI, OP_ORI: begin
            ctrl[C_OUT] = 1'b1; ctrl[Z_IN] = 1'b1; alu_opcode = alu_for(op);
          end
          OP_MUL, OP_DIV: begin
            ctrl[GRB] = 1'b1; ctrl[R_OUT] = 1'b1; ctrl[Z_IN] = 1'b1; alu_opcode = alu_for(op);
          end
          OP_LD, OP_LDI, OP_ST: begin
            ctrl[C_OUT] = 1'b1; ctrl[Z_IN] = 1'b1; alu_opcode = ALU_ADD;
          end
          OP_BR:  begin ctrl[PC_OUT] = 1'b1; ctrl[Y_IN] = 1'b1; end
          OP_JAL: begin ctrl[GRA] = 1'b1; ctrl[R_OUT] = 1'b1; ctrl[PC_IN] = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
          OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: begin
            ctrl[ZLOW_OUT] = 1'b1; ctrl[GRA] = 1'b1; ctrl[R_IN] = 1'b1;
          end
          OP_MUL, OP_DIV: begin ctrl[ZLOW_OUT] = 1'b1; ctrl[LO_IN] = 1'b1; end
          OP_LD, OP_ST:   begin ctrl[ZLOW_OUT] = 1'b1; ctrl[MAR_IN] = 1'b1; end
          OP_BR: begin ctrl[C_OUT] = 1'b1; ctrl[Z_IN] = 1'b1; alu_opcode = ALU_ADD; end
          default: ;
        endcase
      end
      S_T6: begin
        case (op)
          OP_MUL, OP_DIV: begin ctrl[ZHIGH_OUT] = 1'b1; ctrl[HI_IN] = 1'b1; end
          OP_LD: begin ctrl[READ] = 1'b1; ctrl[MDR_IN] = 1'b1; end
          OP_ST: begin ctrl[GRA] = 1'b1; ctrl[R_OUT] = 1'b1; ctrl[MDR_IN] = 1'b1; end
          OP_BR: begin ctrl[ZLOW_OUT] = con_ff; ctrl[PC_IN] = con_ff; end
          default: ;
        endcase
      end
      S_T7: begin
        case (op)
          OP_LD: begin ctrl[MDR_OUT] = 1'b1; ctrl[GRA] = 1'b1; ctrl[R_IN] = 1'b1; end
          OP_ST: ctrl[WRITE] = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb/tb_ctrl_sequencer.sv - directed-vector bench for ctrl_sequencer (MUL_CYCLES=3)
module tb_ctrl_sequencer;

  logic        clock, reset, stop, con_ff, mem_ready;
  logic [31:0] IRdata;
  logic        run, clear;
  logic [26:0] ctrl;
  logic [4:0]  alu_opcode;
  int          total, bad;

  localparam logic [31:0] IR_ADD  = 32'h18918000;
  localparam logic [31:0] IR_MUL  = 32'h78000000;
  localparam logic [31:0] IR_BR   = 32'h98000000;
  localparam logic [31:0] IR_NEG  = 32'h88000000;
  localparam logic [31:0] IR_UNK  = 32'h40000000;
  localparam logic [31:0] IR_LD   = 32'h00800000;
  localparam logic [31:0] IR_HALT = 32'hD8000000;

  ctrl_sequencer #(.MUL_CYCLES(3)) dut (
    .clock(clock), .reset(reset), .stop(stop), .IRdata(IRdata), .con_ff(con_ff),
    .mem_ready(mem_ready), .run(run), .clear(clear), .ctrl(ctrl), .alu_opcode(alu_opcode)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total = total + 1;
    if (got !== want) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cyc(input string tag, input logic [31:0] c, input logic [31:0] a);
    check(tag, 32'(ctrl), c);
    check({tag, ".alu"}, 32'(alu_opcode), a);
    check({tag, ".run"}, 32'(run), 32'd1);
    tick();
  endtask

  task automatic idle(input string tag, input logic r, input logic c);
    check({tag, ".ctrl"}, 32'(ctrl), 32'd0);
    check({tag, ".alu"}, 32'(alu_opcode), 32'd0);
    check({tag, ".run"}, 32'(run), 32'(r));
    check({tag, ".clear"}, 32'(clear), 32'(c));
  endtask

  task automatic fetch(input string tag);
    cyc({tag, ".f0"}, 32'h0000000F, 0);
    cyc({tag, ".f1"}, 32'h000002D0, 0);
    cyc({tag, ".f2"}, 32'h00000C00, 0);
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; stop = 1'b0; con_ff = 1'b0; mem_ready = 1'b1; IRdata = IR_ADD;

    tick(); tick();
    idle("reset", 1'b0, 1'b1);
    reset = 1'b0;
    tick();
    check("reset.f0.clear", 32'(clear), 32'd0);

    // add: 6 cycles then back to F0
    fetch("add");
    cyc("add.t3", 32'h00092000, 0);
    cyc("add.t4", 32'h00014008, 1);
    cyc("add.t5", 32'h00009010, 0);

    IRdata = IR_MUL;
    fetch("mul");
    cyc("mul.t3", 32'h00091000, 0);
    for (int i = 0; i < 3; i++) cyc("mul.t4", 32'h00012008, 3);
    cyc("mul.t5", 32'h00200010, 0);
    cyc("mul.t6", 32'h00100020, 0);

    IRdata = IR_BR; con_ff = 1'b0;
    fetch("br0");
    cyc("br0.t3", 32'h01011000, 0);
    cyc("br0.t4", 32'h00080001, 0);
    cyc("br0.t5", 32'h00040008, 1);
    cyc("br0.t6", 32'h00000000, 0);

    con_ff = 1'b1;
    fetch("br1");
    cyc("br1.t3", 32'h01011000, 0);
    cyc("br1.t4", 32'h00080001, 0);
    cyc("br1.t5", 32'h00040008, 1);
    cyc("br1.t6", 32'h00000050, 0);
    con_ff = 1'b0;

    IRdata = IR_NEG;
    fetch("neg");
    cyc("neg.t3", 32'h00012008, 12);
    cyc("neg.t4", 32'h00009010, 0);

    IRdata = IR_UNK;
    fetch("unk");
    cyc("unk.t3", 32'h00000000, 0);

    IRdata = IR_LD;
    fetch("ld");
    cyc("ld.t3", 32'h000A2000, 0);
    cyc("ld.t4", 32'h00040008, 1);
    cyc("ld.t5", 32'h00000012, 0);
    mem_ready = 1'b0;
`ifdef CTRL_SEQ_MEMWAIT_EN
    for (int i = 0; i < 4; i++) cyc("ld.t6.wait", 32'h00000280, 0);
    mem_ready = 1'b1;
`endif
    cyc("ld.t6", 32'h00000280, 0);
    mem_ready = 1'b1;
    cyc("ld.t7", 32'h00009400, 0);

    // reset in the middle of a load (during the T6 stall when memwait is built in)
    fetch("ldr");
    cyc("ldr.t3", 32'h000A2000, 0);
    cyc("ldr.t4", 32'h00040008, 1);
    cyc("ldr.t5", 32'h00000012, 0);
    mem_ready = 1'b0;
`ifdef CTRL_SEQ_MEMWAIT_EN
    cyc("ldr.t6.wait", 32'h00000280, 0);
`endif
    check("ldr.t6.ctrl", 32'(ctrl), 32'h00000280);
    reset = 1'b1;
    tick();
    idle("ldr.reset", 1'b0, 1'b1);
    reset = 1'b0; mem_ready = 1'b1;
    tick();

    // stop raised from T3: only the completion edge honours it
    IRdata = IR_ADD;
    fetch("stop");
    stop = 1'b1;
    cyc("stop.t3", 32'h00092000, 0);
    cyc("stop.t4", 32'h00014008, 1);
    cyc("stop.t5", 32'h00009010, 0);
    idle("stop.halt", 1'b0, 1'b0);
    stop = 1'b0;
    tick(); tick(); tick();
    idle("stop.halt.stay", 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    idle("stop.reset", 1'b0, 1'b1);
    reset = 1'b0;
    tick();

    IRdata = IR_HALT;
    fetch("halt");
    cyc("halt.t3", 32'h00000000, 0);
    idle("halt.state", 1'b0, 1'b0);
    IRdata = IR_ADD;
    tick(); tick();
    idle("halt.stay", 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    idle("halt.reset", 1'b0, 1'b1);
    reset = 1'b0;
    tick();
    fetch("after");
    cyc("after.t3", 32'h00092000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Parametrised, cycle-accurate microsequencer for the 32-bit three-bus CPU datapath: fetches, decodes `IRdata[31:27]` and drives one datapath control word per clock. It replaces delay-timed state stepping with a single-clock, one-state-per-cycle FSM. It adds memory-ready stalling, a configurable multi-cycle MUL/DIV step, stop/halt handling and synchronous reset. It sits between the testbench/top level and the datapath.

## Interface
- `MUL_CYCLES`, 1, cycles the MUL/DIV compute step (T4) is held (1..15).
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `stop` in 1: request halt at next instruction boundary.
- `IRdata` in 32: IR register contents; valid from T3 onward.
- `con_ff` in 1: branch condition flop output.
- `mem_ready` in 1: memory done; used only with `CTRL_SEQ_MEMWAIT_EN`.
- `run` out 1: 1 unless in HALT or RESET.
- `clear` out 1: 1 only in RESET.
- `ctrl` out 27: strobes, in bit order [0]..[26]: PCout, MARin, incPC, Zin, ZLowOut, ZHighOut, PCin, read, write, MDRin, MDRout, IRin, Gra, Grb, Grc, Rin, Rout, BAout, Cout, Yin, HIin, LOin, HIout, LOout, CONN_in, InPortOut, OutPortIn.
- `alu_opcode` out 5: ALU op. 0 nop, 1 add, 2 sub, 3 mul, 4 div, 5 shr, 6 shl, 8 ror, 9 rol, 10 and, 11 or, 12 neg, 15 not.

## Operation
- IR opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01001, ror 01010, rol 01011, addi 01100, andi 01101, ori 01110, mul 01111, div 10000, neg 10001, not 10010, br 10011, jr 10100, jal 10101, in 10110, out 10111, mfhi 11000, mflo 11001, nop 11010, halt 11011. Any other opcode executes as nop.
- States: RESET, F0, F1, F2, T3..T7 (step counter), MULWAIT count, HALT. Outputs are decoded from the registered state plus `IRdata`/`con_ff`. Unlisted strobes are 0; `alu_opcode` is 0 except where noted.
- F0: PCout MARin incPC Zin.
- F1: ZLowOut PCin read MDRin.
- F2: MDRout IRin. Then go to T3.
- Reg-reg ALU ops (add sub and or shl shr rol ror): T3 Grb Rout Yin; T4 Grc Rout Zin + op; T5 ZLowOut Gra Rin.
- neg/not: T3 Grb Rout Zin + op; T4 ZLowOut Gra Rin.
- addi/andi/ori: T3 Grb Rout Yin; T4 Cout Zin + add/and/or; T5 ZLowOut Gra Rin.
- mul/div: T3 Gra Rout Yin; T4 Grb Rout Zin + op, held MUL_CYCLES cycles; T5 ZLowOut LOin; T6 ZHighOut HIin.
- ld: T3 Grb BAout Yin; T4 Cout Zin add; T5 ZLowOut MARin; T6 read MDRin; T7 MDRout Gra Rin.
- ldi: T3, T4 as ld; T5 ZLowOut Gra Rin.
- st: T3–T5 as ld; T6 Gra Rout MDRin; T7 write.
- br: T3 Gra Rout CONN_in; T4 PCout Yin; T5 Cout Zin add; T6 ZLowOut PCin only if `con_ff`=1, otherwise no strobes.
- jr: T3 Gra Rout PCin.
- jal: T3 PCout Grb Rin; T4 Gra Rout PCin.
- mfhi/mflo/in: T3 HIout/LOout/InPortOut with Gra Rin.
- out: T3 Gra Rout OutPortIn.
- nop: T3 no strobes.
- halt: T3 → HALT.
- Completion: after the last step, go to F0. If `stop`=1 on that edge, go to HALT instead.
- HALT: all strobes 0, `run`=0. HALT is left only by `reset`.

## Timing
- Reset: on `reset`=1 at an edge, the next state is RESET from any state, including mid-instruction or mid-stall. In RESET, `ctrl`=0, `alu_opcode`=0, `clear`=1, `run`=0. RESET lasts 1 cycle, then F0.
- One state per clock. Instruction latency with no stalls:
  - reg-reg ALU 6 cycles; neg/not 5; imm 6; ldi 6; ld/st 8; br 7; jal 5; single-step ops 4.
  - mul/div: 6 + MUL_CYCLES.
- `con_ff` is sampled combinationally in br T6 and is stable since T4.
- A stall keeps all strobes of the stalled state asserted unchanged.

## Configuration
- `CTRL_SEQ_MEMWAIT_EN` defined: F1, ld T6 and st T7 hold until an edge with `mem_ready`=1, then advance. `reset` overrides the stall.
- Not defined: `mem_ready` is ignored and these states take 1 cycle.

## Test plan
- Reset: hold `reset` 2 cycles → `clear`=1, `ctrl`=0 → release → F0 with `ctrl`=0x0000000F (PCout MARin incPC Zin).
- add, IR 0x18918000: exactly 6 cycles F0..T5; T4 `alu_opcode`=1 with Grc Rout Zin; returns to F0.
- mul with MUL_CYCLES=3: T4 strobes held 3 cycles; T5 LOin, T6 HIin; 9 cycles total.
- br: with `con_ff`=0, T6 `ctrl`=0; with `con_ff`=1, T6 ZLowOut PCin asserted.
- With MEMWAIT: ld with `mem_ready` low 4 cycles in T6 → read MDRin held 5 cycles; assert `reset` during the stall → RESET next cycle.
- halt opcode 11011 → HALT, `run`=0. Separately, `stop`=1 during add T5 → HALT instead of F0. Only `reset` exits HALT.
